// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that drains a show-ahead FIFO, one word per frame, LSB first.
// Optional parity bit after the data bits is enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo_reader #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int WIDTH      = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int IW  = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] CNT_MAX = CW'(CPB - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state_q, state_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [IW-1:0]    idx_q, idx_n;
  logic [WIDTH-1:0] shift_q, shift_n;
  logic             tx_q, tx_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_n;
`endif

  logic bit_end;
  logic launch;
  logic launch_pt;

  assign bit_end = (cnt_q == CNT_MAX);
  assign launch  = enable && !fifo_empty;

  // Launch points: idle, or the last cycle of a stop bit (gapless chaining).
  assign launch_pt = launch &&
                     ((state_q == IDLE) ||
                      ((state_q == STOP) && bit_end));

  assign fifo_rd_en = launch_pt && !rst;

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    shift_n = shift_q;
    tx_n    = tx_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif

    if ((state_q != IDLE) && !bit_end)
      cnt_n = cnt_q + CW'(1);

    unique case (state_q)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        cnt_n  = '0;
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          cnt_n   = '0;
          tx_n    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shift_n = shift_q >> 1;
          if (idx_q == IDX_MAX) begin
            idx_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par_q;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            idx_n = idx_q + IW'(1);
            tx_n  = shift_n[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          cnt_n   = '0;
          tx_n    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          cnt_n   = '0;
          tx_n    = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase

    // The word sampled here is the one the FIFO discards on this edge.
    if (launch_pt) begin
      state_n = START;
      shift_n = fifo_data;
      cnt_n   = '0;
      idx_n   = '0;
      tx_n    = 1'b0;
      busy_n  = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_n   = (^fifo_data) ^ PARITY_ODD;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      shift_q <= shift_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

endmodule
